// File: rtl/gps_corr_dump_pkg.sv
// Shared definitions for the integrate-and-dump correlator.
//   - default sample and accumulator widths
//   - controller state encoding (IDLE, ARM, RUN)
//   - saturation limits for the default accumulator width
package gps_corr_pkg;

  localparam int SAMPLE_W_DEF = 3;
  localparam int ACC_W_DEF    = 20;
  localparam int NUM_ARMS     = 6;  // IE, QE, IP, QP, IL, QL

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Saturation limits at the default width; corr_arm derives the same
  // pattern for whatever ACC_W it is built with.
  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/gps_corr_dump_if.sv
// Dump result bus between the correlator and the tracking-loop processor.
//   ie..ql      held integration results (signed, ACC_W)
//   dump_valid  held results are new and unconsumed
//   dump_ack    consumer accepts the held results
//   overrun     sticky: a dump overwrote unacked results
//   sat         an accumulator saturated during the held integration
//
// Handshake: the master raises dump_valid with new results; the transfer
// completes on any rising clk edge where dump_valid=1 and dump_ack=1.
// dump_ack while dump_valid=0 has no effect. A new dump in the same cycle
// as an ack replaces the results and keeps dump_valid high.
interface gps_corr_dump_if #(
  parameter int ACC_W = 20
);
  logic signed [ACC_W-1:0] ie, qe, ip, qp, il, ql;
  logic dump_valid;
  logic dump_ack;
  logic overrun;
  logic sat;

  modport master (
    output ie, qe, ip, qp, il, ql, dump_valid, overrun, sat,
    input  dump_ack
  );

  modport slave (
    input  ie, qe, ip, qp, il, ql, dump_valid, overrun, sat,
    output dump_ack
  );
endinterface

// File: rtl/gps_corr_dump_corr_arm.sv
// One correlator arm: sample times a +/-1 code replica, accumulated with
// saturation, plus a sticky saturation flag for the current integration.
//   clk, res   clock, async active-high reset
//   sample     signed input sample
//   code       0 -> multiply by +1, 1 -> multiply by -1
//   clr        clear accumulator and flag (highest priority)
//   load       start a new integration with this cycle's product
//   add        accumulate this cycle's product
//   smp_en     product is valid this cycle
//   acc        accumulator value
//   sat_flag   saturation occurred since the last clr/load
module corr_arm
  import gps_corr_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       code,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       add,
  input  logic                       smp_en,
  output logic signed [ACC_W-1:0]    acc,
  output logic                       sat_flag
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W:0]   sum;
  logic                    ovf;
  logic signed [ACC_W-1:0] sum_sat;

  // Extend before negating so the most-negative sample flips cleanly.
  assign ext  = {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
  assign prod = code ? -ext : ext;

  // One guard bit: overflow shows as a disagreement of the top two bits.
  assign sum     = {acc[ACC_W-1], acc} + {prod[ACC_W-1], prod};
  assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
  assign sum_sat = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (load) begin
      acc      <= smp_en ? prod : '0;
      sat_flag <= 1'b0;
    end else if (add && smp_en) begin
      acc <= sum_sat;
      if (ovf) sat_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/gps_corr_dump.sv
// Integrate-and-dump correlator for one tracking channel.
//   clk, res       sample clock, async active-high reset
//   enable         channel enable (level)
//   int_len        integration length in code epochs (0 acts as 1)
//   sample_en      qualifies samples and code bits this cycle
//   i/q_sample     signed baseband samples
//   pne/pnp/pnl    early/prompt/late code bits (1 = negate)
//   epoch          first-chip pulse of each code period
//   dump           result bus (master side), see gps_corr_dump_if
//   state_dbg      controller state
module gps_corr_dump
  import gps_corr_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       enable,
  input  logic [4:0]                 int_len,
  input  logic                       sample_en,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic signed [SAMPLE_W-1:0] q_sample,
  input  logic                       pne,
  input  logic                       pnp,
  input  logic                       pnl,
  input  logic                       epoch,
  gps_corr_dump_if.master            dump,
  output state_t                     state_dbg
);

  state_t                  state_q;
  logic [4:0]              cnt_q;
  logic [4:0]              tgt_q;
  logic signed [ACC_W-1:0] hold_q [NUM_ARMS];
  logic                    valid_q;
  logic                    ovr_q;
  logic                    sat_q;

  logic signed [ACC_W-1:0] acc [NUM_ARMS];
  logic [NUM_ARMS-1:0]     arm_sat;
  logic [2:0]              code_v;
  logic [4:0]              len_eff;
  logic                    arm_clr, arm_load, arm_add;
  logic                    start, do_dump, ack_ok;

  assign code_v = {pnl, pnp, pne};

  always_comb begin
    len_eff  = (int_len == 5'd0) ? 5'd1 : int_len;
    start    = enable && epoch && (state_q == ARM);
    do_dump  = enable && epoch && (state_q == RUN) && (cnt_q == tgt_q);
    arm_clr  = (state_q == IDLE) || !enable;
    arm_load = start || do_dump;
    arm_add  = enable && (state_q == RUN) && !do_dump;
    ack_ok   = dump.dump_ack && valid_q;
  end

  // Arm k: even k uses I, odd k uses Q; k/2 selects early/prompt/late.
  for (genvar k = 0; k < NUM_ARMS; k++) begin : g_arm
    corr_arm #(
      .SAMPLE_W (SAMPLE_W),
      .ACC_W    (ACC_W)
    ) u_arm (
      .clk      (clk),
      .res      (res),
      .sample   ((k % 2 == 0) ? i_sample : q_sample),
      .code     (code_v[k/2]),
      .clr      (arm_clr),
      .load     (arm_load),
      .add      (arm_add),
      .smp_en   (sample_en),
      .acc      (acc[k]),
      .sat_flag (arm_sat[k])
    );
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      tgt_q   <= 5'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      sat_q   <= 1'b0;
      for (int k = 0; k < NUM_ARMS; k++) hold_q[k] <= '0;
    end else begin
      // Controller and epoch counter
      if (!enable) begin
        state_q <= IDLE;
        cnt_q   <= 5'd0;
      end else begin
        case (state_q)
          IDLE: state_q <= ARM;
          ARM: begin
            if (epoch) begin
              state_q <= RUN;
              cnt_q   <= 5'd1;
              tgt_q   <= len_eff;
            end
          end
          RUN: begin
            if (epoch) begin
              if (cnt_q == tgt_q) begin
                cnt_q <= 5'd1;
                tgt_q <= len_eff;
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      // Hold registers and handshake
      if (do_dump) begin
        for (int k = 0; k < NUM_ARMS; k++) hold_q[k] <= acc[k];
        sat_q   <= |arm_sat;
        valid_q <= 1'b1;
      end else if (ack_ok) begin
        valid_q <= 1'b0;
      end

      // An ack wins over a coincident dump for the overrun flag.
      if (ack_ok)                  ovr_q <= 1'b0;
      else if (do_dump && valid_q) ovr_q <= 1'b1;
    end
  end

  assign dump.ie         = hold_q[0];
  assign dump.qe         = hold_q[1];
  assign dump.ip         = hold_q[2];
  assign dump.qp         = hold_q[3];
  assign dump.il         = hold_q[4];
  assign dump.ql         = hold_q[5];
  assign dump.dump_valid = valid_q;
  assign dump.overrun    = ovr_q;
  assign dump.sat        = sat_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_gps_corr_dump.sv
// Bench for gps_corr_dump: a default-width instance (A, ACC_W=20) and a
// narrow instance (B, ACC_W=12) share all stimulus.
module tb_gps_corr_dump;
  import gps_corr_pkg::*;

  localparam int PW = 6 * 20 + 5;  // {state, valid, overrun, sat, 6 x 20-bit results}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  logic              enable, sample_en, pne, pnp, pnl, epoch, ack;
  logic [4:0]        int_len;
  logic signed [2:0] i_sample, q_sample;
  state_t            st_a, st_b;

  gps_corr_dump_if #(.ACC_W(20)) bus_a ();
  gps_corr_dump_if #(.ACC_W(12)) bus_b ();
  assign bus_a.dump_ack = ack;
  assign bus_b.dump_ack = ack;

  gps_corr_dump #(.SAMPLE_W(3), .ACC_W(20)) dut_a (
    .clk(clk), .res(res), .enable(enable), .int_len(int_len), .sample_en(sample_en),
    .i_sample(i_sample), .q_sample(q_sample), .pne(pne), .pnp(pnp), .pnl(pnl),
    .epoch(epoch), .dump(bus_a), .state_dbg(st_a)
  );

  gps_corr_dump #(.SAMPLE_W(3), .ACC_W(12)) dut_b (
    .clk(clk), .res(res), .enable(enable), .int_len(int_len), .sample_en(sample_en),
    .i_sample(i_sample), .q_sample(q_sample), .pne(pne), .pnp(pnp), .pnl(pnl),
    .epoch(epoch), .dump(bus_b), .state_dbg(st_b)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  bit model_chk = 1'b0;
  logic [PW-1:0] exp_q[$];

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Sums are plain integers clamped to the instance's signed range.
  state_t m_st    [2];
  longint m_sum   [2][6];
  longint m_hold  [2][6];
  bit     m_flag  [2];
  int     m_cnt   [2];
  int     m_tgt   [2];
  bit     m_valid [2];
  bit     m_ovr   [2];
  bit     m_sat   [2];
  bit     m_dumped[2];
  int     m_w     [2] = '{20, 12};

  function automatic longint prod(int k);
    int s;
    logic c;
    s = (k % 2 == 0) ? int'(i_sample) : int'(q_sample);
    c = (k / 2 == 0) ? pne : ((k / 2 == 1) ? pnp : pnl);
    return c ? -longint'(s) : longint'(s);
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = IDLE; m_flag[d] = 0; m_cnt[d] = 0; m_tgt[d] = 0;
      m_valid[d] = 0; m_ovr[d] = 0; m_sat[d] = 0; m_dumped[d] = 0;
      for (int k = 0; k < 6; k++) begin m_sum[d][k] = 0; m_hold[d][k] = 0; end
    end
  endtask

  task automatic m_restart(int d);
    for (int k = 0; k < 6; k++) m_sum[d][k] = sample_en ? prod(k) : 0;
    m_flag[d] = 0;
    m_cnt[d]  = 1;
    m_tgt[d]  = (int_len == 0) ? 1 : int'(int_len);
  endtask

  task automatic m_step(int d);
    longint hi, lo, s;
    bit dmp;
    bit acked;
    hi    = (longint'(1) <<< (m_w[d] - 1)) - 1;
    lo    = -hi - 1;
    dmp   = 0;
    acked = ack && m_valid[d];
    if (!enable) begin
      m_st[d] = IDLE; m_cnt[d] = 0; m_flag[d] = 0;
      for (int k = 0; k < 6; k++) m_sum[d][k] = 0;
    end else if (m_st[d] == IDLE) begin
      m_st[d] = ARM;
    end else if (m_st[d] == ARM) begin
      if (epoch) begin m_st[d] = RUN; m_restart(d); end
    end else if (epoch && m_cnt[d] == m_tgt[d]) begin
      dmp = 1;
      for (int k = 0; k < 6; k++) m_hold[d][k] = m_sum[d][k];
      m_sat[d] = m_flag[d];
      m_restart(d);
    end else begin
      if (epoch) m_cnt[d]++;
      if (sample_en)
        for (int k = 0; k < 6; k++) begin
          s = m_sum[d][k] + prod(k);
          if (s > hi) begin s = hi; m_flag[d] = 1; end
          if (s < lo) begin s = lo; m_flag[d] = 1; end
          m_sum[d][k] = s;
        end
    end
    if (dmp) begin
      if (m_valid[d] && !ack) m_ovr[d] = 1;
      else if (acked)         m_ovr[d] = 0;
      m_valid[d] = 1;
    end else if (acked) begin
      m_valid[d] = 0;
      m_ovr[d]   = 0;
    end
    m_dumped[d] = dmp;
  endtask

  function automatic logic [PW-1:0] m_pack(int d);
    logic [PW-1:0] r;
    r = {2'(m_st[d]), m_valid[d], m_ovr[d], m_sat[d], 120'd0};
    for (int k = 0; k < 6; k++) r[(5-k)*20 +: 20] = 20'(m_hold[d][k]);
    return r;
  endfunction

  function automatic logic [PW-1:0] dut_pack(int d);
    if (d == 0)
      return {2'(st_a), bus_a.dump_valid, bus_a.overrun, bus_a.sat,
              bus_a.ie, bus_a.qe, bus_a.ip, bus_a.qp, bus_a.il, bus_a.ql};
    return {2'(st_b), bus_b.dump_valid, bus_b.overrun, bus_b.sat,
            {{8{bus_b.ie[11]}}, bus_b.ie}, {{8{bus_b.qe[11]}}, bus_b.qe},
            {{8{bus_b.ip[11]}}, bus_b.ip}, {{8{bus_b.qp[11]}}, bus_b.qp},
            {{8{bus_b.il[11]}}, bus_b.il}, {{8{bus_b.ql[11]}}, bus_b.ql}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_step(d);
      if (m_dumped[d]) exp_q.push_back(m_pack(d));
    end
    for (int d = 0; d < 2; d++) begin
      if (m_dumped[d] && exp_q.size() > 0)
        chk_vec(d == 0 ? "dump_payload_a" : "dump_payload_b", dut_pack(d), exp_q.pop_front());
      if (model_chk)
        chk_vec(d == 0 ? "cycle_a" : "cycle_b", dut_pack(d), m_pack(d));
    end
  endtask

  task automatic set_smp(int i, int q, bit ce, bit cp, bit cl);
    i_sample = 3'(i); q_sample = 3'(q); pne = ce; pnp = cp; pnl = cl;
  endtask

  task automatic do_reset();
    enable = 0; epoch = 0; ack = 0; sample_en = 0; int_len = 0;
    set_smp(0, 0, 0, 0, 0);
    res = 1;
    #1;
    m_reset();
    chk_vec("reset_a", dut_pack(0), '0);
    chk_vec("reset_b", dut_pack(1), '0);
    @(posedge clk);
    #1;
    res = 0;
  endtask

  task automatic pulse_then(int quiet);
    epoch = 1; step();
    epoch = 0; repeat (quiet) step();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int len; int isamp; int qsamp; bit ce; bit cp; bit cl;
    int e_ie; int e_qe; int e_ip; int e_qp; int e_il; int e_ql;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int leff;
    int per;
    int ph;

    vecs[0] = '{1,  3,  0, 0, 0, 0,  3069,     0,  3069,     0,  3069,     0};
    vecs[1] = '{1,  3, -2, 0, 1, 0,  3069, -2046, -3069,  2046,  3069, -2046};
    vecs[2] = '{1, -4,  1, 0, 0, 1, -4092,  1023, -4092,  1023,  4092, -1023};
    vecs[3] = '{3,  1, -1, 0, 0, 0,  3069, -3069,  3069, -3069,  3069, -3069};
    vecs[4] = '{0,  2,  3, 1, 0, 1, -2046, -3069,  2046,  3069, -2046, -3069};
    vecs[5] = '{2, -1, -4, 1, 1, 0,  2046,  8184,  2046,  8184, -2046, -8184};

    res = 1;
    do_reset();

    // Constant-sample integrations, 1023 samples per code period.
    foreach (vecs[v]) begin
      do_reset();
      leff = (vecs[v].len == 0) ? 1 : vecs[v].len;
      enable = 1; sample_en = 1; int_len = 5'(vecs[v].len);
      set_smp(vecs[v].isamp, vecs[v].qsamp, vecs[v].ce, vecs[v].cp, vecs[v].cl);
      step();
      chk("vec_arm_state", st_a, ARM);
      for (int e = 1; e <= leff + 1; e++) begin
        epoch = 1; step(); epoch = 0;
        chk("vec_valid", bus_a.dump_valid, (e == leff + 1) ? 1 : 0);
        if (e <= leff) repeat (1022) step();
      end
      chk("vec_ie", bus_a.ie, vecs[v].e_ie);
      chk("vec_qe", bus_a.qe, vecs[v].e_qe);
      chk("vec_ip", bus_a.ip, vecs[v].e_ip);
      chk("vec_qp", bus_a.qp, vecs[v].e_qp);
      chk("vec_il", bus_a.il, vecs[v].e_il);
      chk("vec_ql", bus_a.ql, vecs[v].e_ql);
      chk("vec_sat", bus_a.sat, 0);
    end

    // Saturation on the 12-bit instance, then a clean integration.
    do_reset();
    enable = 1; sample_en = 1; int_len = 2;
    set_smp(3, 0, 1, 0, 0);
    step();
    pulse_then(1022);
    pulse_then(1022);
    set_smp(1, 0, 1, 0, 0);
    epoch = 1; step(); epoch = 0;
    chk("sat_ip_b", bus_b.ip, 2047);
    chk("sat_ie_b", bus_b.ie, -2048);
    chk("sat_flag_b", bus_b.sat, 1);
    chk("sat_ip_a", bus_a.ip, 6138);
    chk("sat_flag_a", bus_a.sat, 0);
    repeat (1022) step();
    pulse_then(1022);
    epoch = 1; step(); epoch = 0;
    chk("clean_ip_b", bus_b.ip, 2046);
    chk("clean_ie_b", bus_b.ie, -2046);
    chk("clean_sat_b", bus_b.sat, 0);

    // Overrun and ack corner cases, 10 samples per period.
    model_chk = 1;
    do_reset();
    enable = 1; sample_en = 1; int_len = 1;
    set_smp(1, 0, 0, 0, 0);
    step();
    pulse_then(9);
    set_smp(2, 0, 0, 0, 0);
    epoch = 1; step(); epoch = 0;
    chk("ovr_d1_ip", bus_a.ip, 10);
    chk("ovr_d1_valid", bus_a.dump_valid, 1);
    chk("ovr_d1_ovr", bus_a.overrun, 0);
    repeat (9) step();
    set_smp(3, 0, 0, 0, 0);
    epoch = 1; step(); epoch = 0;
    chk("ovr_d2_ip", bus_a.ip, 20);
    chk("ovr_d2_ovr", bus_a.overrun, 1);
    repeat (9) step();
    epoch = 1; ack = 1; step(); epoch = 0;
    chk("ack_dump_ip", bus_a.ip, 30);
    chk("ack_dump_valid", bus_a.dump_valid, 1);
    chk("ack_dump_ovr", bus_a.overrun, 0);
    step();
    chk("ack_clears_valid", bus_a.dump_valid, 0);
    step();
    ack = 0;
    chk("idle_ack_valid", bus_a.dump_valid, 0);
    chk("idle_ack_ip", bus_a.ip, 30);

    // Enable dropped on a would-be dump epoch, then re-armed.
    repeat (8) step();
    enable = 0; epoch = 1; step(); epoch = 0;
    chk("drop_state", st_a, IDLE);
    chk("drop_no_dump", bus_a.dump_valid, 0);
    enable = 1; epoch = 1; step(); epoch = 0;
    chk("rise_epoch_ignored", st_a, ARM);
    repeat (5) step();
    set_smp(-2, 1, 0, 0, 0);
    pulse_then(9);
    epoch = 1; step(); epoch = 0;
    chk("rearm_ip", bus_a.ip, -20);
    chk("rearm_qp", bus_a.qp, 10);
    chk("rearm_valid", bus_a.dump_valid, 1);

    // Asynchronous reset in the middle of an integration.
    repeat (4) step();
    #2;
    res = 1;
    #1;
    chk_vec("async_reset_a", dut_pack(0), '0);
    chk_vec("async_reset_b", dut_pack(1), '0);
    m_reset();
    enable = 0; ack = 0; epoch = 0;
    @(posedge clk);
    #1;
    res = 0;

    // Randomised traffic against the model.
    per = 10; ph = 0;
    for (int n = 0; n < 4000; n++) begin
      enable    = ($urandom_range(0, 299) != 0);
      sample_en = ($urandom_range(0, 3) != 0);
      set_smp(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      epoch = (ph == 0);
      if (epoch) int_len = 5'($urandom_range(0, 4));
      ph++;
      if (ph == per) begin ph = 0; per = $urandom_range(6, 25); end
      ack = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gps_corr_dump.md
# gps_corr_dump

Integrate-and-dump correlator for one tracking channel: the consumer of the early/prompt/late PN code bits and the code-epoch pulse produced by the code generator. Each enabled sample cycle, it multiplies the signed baseband I and Q samples by ±1 according to each code replica. It accumulates the six products (IE, QE, IP, QP, IL, QL) over a programmable number of code epochs. At the integration boundary, it dumps the six sums to a holding register and presents them to the tracking-loop processor through a valid/ack handshake.

## Interface
Parameters:
- SAMPLE_W, default 3: signed two's-complement width of the I and Q samples.
- ACC_W, default 20: signed width of each accumulator and dump register.

Ports:
- clk  in  1  Sample clock; the single clock of the block. All logic is on the rising edge.
- res  in  1  Reset, asynchronous and active-high.
- enable  in  1  Channel enable; a level signal.
- int_len  in  5  Integration length in code epochs. 0 is treated as 1.
- sample_en  in  1  Qualifies i_sample, q_sample, pne, pnp and pnl on this cycle.
- i_sample  in  SAMPLE_W  In-phase sample, signed.
- q_sample  in  SAMPLE_W  Quadrature sample, signed.
- pne, pnp, pnl  in  1 each  Early, prompt and late code bits. 0 means multiply by +1; 1 means multiply by −1.
- epoch  in  1  Single-cycle pulse, synchronous to clk, marking the first chip of a code period.
- ie, qe, ip, qp, il, ql  out  ACC_W each  Held dump results, signed.
- dump_valid  out  1  The held results are new and unconsumed.
- dump_ack  in  1  Consumer accepts the held results.
- overrun  out  1  Sticky flag: a dump overwrote unacked results.
- sat  out  1  At least one accumulator saturated during the held integration.

## Operation
- The state machine has three states: IDLE, ARM and RUN.
  - IDLE: accumulators and epoch counter are held at 0. The block moves to ARM when enable=1.
  - ARM: the block waits for epoch=1. On that cycle it moves to RUN and loads the accumulators with the current products (if sample_en=1, else 0). The epoch counter is set to 1.
  - RUN: on each sample_en=1 cycle, every accumulator adds its product.
- On epoch=1 in RUN with epoch counter = max(int_len,1), a dump occurs:
  - The accumulator values are copied to the hold registers, excluding the current sample.
  - The accumulators reload with the current product, or 0 if sample_en=0.
  - The counter resets to 1.
- On epoch=1 in RUN with the counter below target, the counter increments and the accumulation continues.
- int_len is sampled only at dumps and at the ARM→RUN transition.
- If enable=0 in any state, the block goes to IDLE on the next edge and the accumulators clear. No dump occurs. The hold registers, dump_valid and overrun are unaffected.
- Product arithmetic:
  - The product is the sample, or its two's-complement negation, sign-extended to ACC_W.
  - Negating the most-negative sample (−4 for SAMPLE_W=3) gives +4; the sign extension happens first, so no overflow occurs.
- Accumulation saturates at +2^(ACC_W−1)−1 and −2^(ACC_W−1).
  - Any saturation sets an internal flag.
  - The flag is copied to sat at dump and cleared with the accumulators.
- Handshake rules:
  - A dump sets dump_valid=1.
  - dump_ack=1 while dump_valid=1 clears dump_valid and overrun.
  - A dump while dump_valid=1 and dump_ack=0 overwrites the hold registers and sets overrun.
  - Simultaneous dump and ack: the new data loads, dump_valid stays 1, and overrun is cleared and not set.
  - dump_ack while dump_valid=0 is ignored.

## Timing
- Reset values: all six result outputs 0; dump_valid, overrun and sat 0; state IDLE; accumulators and counter 0.
- Latency from input to accumulator: 1 clk.
- Dump latency: the hold registers and dump_valid update on the edge ending the epoch cycle, and are visible the cycle after epoch=1.
- An epoch in the same cycle as enable rising is not seen by ARM; arming takes effect the following cycle.
- Reset asserted mid-integration discards all state asynchronously. After release, the block restarts in IDLE.

## Structure
- Package gps_corr_pkg holds:
  - SAMPLE_W and ACC_W defaults;
  - the state enum {IDLE, ARM, RUN};
  - the saturation limit constants.
- Sub-module corr_arm contains one signed product, a saturating accumulator and a sat flag. It is instantiated six times, once per I/Q × E/P/L combination.
- The top level contains the state machine, the epoch counter, the hold registers and the handshake.

## Test plan
- int_len=1, i_sample=+3 constant, pnp=0, 1023 sample_en cycles between epochs → ip=3069, qp=0, dump_valid pulses high one cycle after the second epoch.
- Same as above with pnp=1 and pne=0 → ip=−3069, ie=+3069. With i_sample=−4 and pnl=1 → il=+4092.
- int_len=3, three epochs of i_sample=+1, pnp=0 → exactly one dump with ip=3069 after the fourth epoch pulse. int_len=0 → behaves as 1.
- ACC_W=12, i_sample=+3, 1023×2 samples with int_len=2 → ip=2047, sat=1. The next clean integration gives sat=0.
- Two dumps without dump_ack → overrun=1 and the hold registers show the second result. Ack coincident with a third dump → dump_valid stays 1 and overrun=0.
- enable dropped mid-RUN → no dump occurs, state returns to IDLE. Re-enable → the first dump covers only the samples after the next epoch. Reset asserted mid-RUN → all outputs 0 immediately.
